// File: rtl/bit_addr_mem_if.sv
// Request/response bus of the bit-addressable data memory.
// The requester drives the master side; bit_addr_mem takes the slave side.
interface bit_addr_mem_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 7
);
    localparam int BSELWIDTH = $clog2(DATAWIDTH);

    logic                 CS;
    logic                 RW;
    logic                 BIT;
    logic [ADDRWIDTH-1:0] addr;
    logic [BSELWIDTH-1:0] bsel;
    logic [DATAWIDTH-1:0] din;
    logic [DATAWIDTH-1:0] dout;
    logic                 bout;
    logic                 rvalid;
    logic                 busy;

    modport master (
        output CS, RW, BIT, addr, bsel, din,
        input  dout, bout, rvalid, busy
    );

    modport slave (
        input  CS, RW, BIT, addr, bsel, din,
        output dout, bout, rvalid, busy
    );
endinterface

// File: rtl/bit_addr_mem.sv
// Single-port data memory with word/bit access, registered reads and a clear sequence after reset.
// Optional macro TRISTATE_EN: dout/bout float (z) outside the rvalid cycle.
module bit_addr_mem #(
    parameter int                 DATAWIDTH = 8,
    parameter int                 ADDRWIDTH = 7,
    parameter int                 DEPTH     = 2**ADDRWIDTH,
    parameter logic [DATAWIDTH-1:0] CLEAR_VAL = '0
) (
    input logic           clk,
    input logic           rst_n,
    bit_addr_mem_if.slave bus
);
    localparam int BSELWIDTH = $clog2(DATAWIDTH);
    localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RMW
    } state_t;

    state_t               state, state_nxt;
    logic [ADDRWIDTH-1:0] cnt, cnt_nxt;
    logic [ADDRWIDTH-1:0] addr_l;
    logic [BSELWIDTH-1:0] bsel_l;
    logic                 din_l;
    logic [DATAWIDTH-1:0] dout_r;
    logic                 bout_r;
    logic                 rvalid_r;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic                 we;
    logic [ADDRWIDTH-1:0] waddr;
    logic [DATAWIDTH-1:0] wdata;
    logic [DATAWIDTH-1:0] rmw_word;
    logic                 rd_word;
    logic                 rd_bit;
    logic                 latch;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = 1'b0;
        waddr     = bus.addr;
        wdata     = bus.din;
        rd_word   = 1'b0;
        rd_bit    = 1'b0;
        latch     = 1'b0;
        rmw_word  = mem[addr_l];
        rmw_word[bsel_l] = din_l;

        unique case (state)
            INIT: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = CLEAR_VAL;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (!bus.CS) begin
                    unique case ({bus.RW, bus.BIT})
                        2'b00: we      = 1'b1;
                        2'b10: rd_word = 1'b1;
                        2'b11: rd_bit  = 1'b1;
                        2'b01: begin
                            latch     = 1'b1;
                            state_nxt = RMW;
                        end
                    endcase
                end
            end
            RMW: begin
                // Read-modify-write uses only the latched request; bus inputs are ignored here.
                we        = 1'b1;
                waddr     = addr_l;
                wdata     = rmw_word;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            addr_l   <= '0;
            bsel_l   <= '0;
            din_l    <= 1'b0;
            dout_r   <= '0;
            bout_r   <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rvalid_r <= rd_word | rd_bit;
            if (latch) begin
                addr_l <= bus.addr;
                bsel_l <= bus.bsel;
                din_l  <= bus.din[0];
            end
            if (rd_word) dout_r <= mem[bus.addr];
            if (rd_bit)  bout_r <= mem[bus.addr][bus.bsel];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign bus.busy   = (state != IDLE);
    assign bus.rvalid = rvalid_r;

`ifdef TRISTATE_EN
    assign bus.dout = rvalid_r ? dout_r : 'z;
    assign bus.bout = rvalid_r ? bout_r : 1'bz;
`else
    assign bus.dout = dout_r;
    assign bus.bout = bout_r;
`endif
endmodule

// File: tb/tb_bit_addr_mem.sv
// Scoreboard bench for bit_addr_mem (DATAWIDTH=8, ADDRWIDTH=3); build with or without TRISTATE_EN.
module tb_bit_addr_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       isbit;
        logic [7:0] d;
        logic       b;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    bit_addr_mem_if #(.DATAWIDTH(8), .ADDRWIDTH(3)) bus ();

    bit_addr_mem #(.DATAWIDTH(8), .ADDRWIDTH(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 expected no response");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.isbit) chk(e.nm, {31'd0, bus.bout}, {31'd0, e.b});
                else         chk(e.nm, {24'd0, bus.dout}, {24'd0, e.d});
            end
        end
`ifdef TRISTATE_EN
        else if (rst_n && bus.rvalid === 1'b0) begin
            checks++;
            if (bus.dout !== 8'hzz || bus.bout !== 1'bz) begin
                errors++;
                $display("FAIL idle_z: got dout=%h bout=%b expected dout=zz bout=z", bus.dout, bus.bout);
            end
        end
`endif
    end

    task automatic drive(input logic rw, input logic b, input logic [2:0] a,
                         input logic [2:0] bs, input logic [7:0] d);
        bus.CS = 1'b0; bus.RW = rw; bus.BIT = b;
        bus.addr = a; bus.bsel = bs; bus.din = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.CS = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_word(input logic [2:0] a, input logic [7:0] exp, input string nm);
        exp_t e;
        e.isbit = 1'b0; e.d = exp; e.b = 1'b0; e.nm = nm;
        sbq.push_back(e);
        drive(1'b1, 1'b0, a, 3'd0, 8'h00);
    endtask

    task automatic rd_bit(input logic [2:0] a, input logic [2:0] bs, input logic exp, input string nm);
        exp_t e;
        e.isbit = 1'b1; e.d = 8'h00; e.b = exp; e.nm = nm;
        sbq.push_back(e);
        drive(1'b1, 1'b1, a, bs, 8'h00);
    endtask

    // Counts posedges after reset release until busy drops (bounded).
    task automatic busy_posedges(output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({nm, "_rvalid"}, {31'd0, bus.rvalid}, 32'd0);
`ifdef TRISTATE_EN
        chk({nm, "_dout"}, {24'd0, bus.dout}, {24'd0, 8'hzz});
        chk({nm, "_bout"}, {31'd0, bus.bout}, {31'd0, 1'bz});
`else
        chk({nm, "_dout"}, {24'd0, bus.dout}, 32'd0);
        chk({nm, "_bout"}, {31'd0, bus.bout}, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.CS = 1'b1; bus.RW = 1'b1; bus.BIT = 1'b0;
        bus.addr = '0; bus.bsel = '0; bus.din = '0;

        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        // Hold a write to addr 0 during INIT; it must be ignored.
        bus.CS = 1'b0; bus.RW = 1'b0; bus.BIT = 1'b0; bus.addr = 3'd0; bus.din = 8'hFF;
        rst_n = 1'b1;
        busy_posedges(n);
        chk("init_busy_posedges", n, 32'd8);

        for (int unsigned a = 0; a < 8; a++) rd_word(3'(a), 8'h00, "init_clear_read");

        drive(1'b0, 1'b0, 3'd5, 3'd0, 8'hA5);
        rd_word(3'd5, 8'hA5, "word_rw_a5");
        idle(1);

        drive(1'b0, 1'b1, 3'd5, 3'd1, 8'h01);
        chk("rmw_busy_high", {31'd0, bus.busy}, 32'd1);
        idle(1);
        chk("rmw_busy_low", {31'd0, bus.busy}, 32'd0);
        rd_word(3'd5, 8'hA7, "rmw_word_a7");
        rd_bit(3'd5, 3'd7, 1'b1, "bit7");
        rd_bit(3'd5, 3'd6, 1'b0, "bit6");
        rd_bit(3'd5, 3'd0, 1'b1, "bit0");
        idle(2);
`ifdef TRISTATE_EN
        chk("idle_dout_z", {24'd0, bus.dout}, {24'd0, 8'hzz});
`else
        chk("dout_hold_a7", {24'd0, bus.dout}, 32'h0000_00A7);
        chk("bout_hold", {31'd0, bus.bout}, 32'd1);
`endif

        // Bit-write addr 5 bit 7 -> 0, then a word write issued in RMW must be dropped.
        drive(1'b0, 1'b1, 3'd5, 3'd7, 8'h00);
        drive(1'b0, 1'b0, 3'd2, 3'd0, 8'h3C);
        chk("after_drop_busy", {31'd0, bus.busy}, 32'd0);
        rd_word(3'd2, 8'h00, "dropped_write_addr2");
        rd_word(3'd5, 8'h27, "rmw_clear_bit7");
        idle(1);

        // Reset in the middle of an RMW.
        drive(1'b0, 1'b1, 3'd5, 3'd0, 8'h00);
        bus.CS = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("rmw_reset");
        @(negedge clk);
        rst_n = 1'b1;
        busy_posedges(n);
        chk("rmw_reset_busy_posedges", n, 32'd8);
        rd_word(3'd5, 8'h00, "post_reset_addr5");
        idle(3);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
